// File: rtl/ram_portb_scheduler.sv
// Data-RAM port B owner: zero-fills the RAM after reset or on request, then arbitrates
// the port between VGA scanout reads (priority) and a debug requester with bounded starvation.
module ram_portb_scheduler #(
  parameter int unsigned  DATA_WIDTH         = 16,
  parameter int unsigned  RAM_REGISTER_COUNT = 1024,
  parameter bit           CLEAR_ON_RESET     = 1'b1,
  parameter int unsigned  DBG_MAX_WAIT       = 15,
  localparam int unsigned ADDR_WIDTH         = $clog2(RAM_REGISTER_COUNT)
) (
  input  logic                  CLK_50,
  input  logic                  reset,
  input  logic                  clear_start,
  output logic                  clear_busy,
  input  logic                  vga_req,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  output logic [DATA_WIDTH-1:0] vga_rdata,
  output logic                  vga_rvalid,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_rvalid,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam int unsigned PtrWidth    = ADDR_WIDTH + 1;
  localparam int unsigned StarveWidth = (DBG_MAX_WAIT > 0) ? $clog2(DBG_MAX_WAIT + 1) : 1;
  localparam logic [PtrWidth-1:0]    LastPtr   = PtrWidth'(RAM_REGISTER_COUNT - 1);
  localparam logic [StarveWidth-1:0] StarveMax = StarveWidth'(DBG_MAX_WAIT);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e                 state_q, state_d;
  logic [PtrWidth-1:0]    clear_ptr_q, clear_ptr_d;
  logic [StarveWidth-1:0] starve_q, starve_d;
  logic                   vga_slot_q, vga_slot_d;
  logic                   dbg_rd_q, dbg_rd_d;
  logic [DATA_WIDTH-1:0]  vga_hold_q, dbg_hold_q;
  logic                   dbg_win;

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    starve_d    = starve_q;
    vga_slot_d  = 1'b0;
    dbg_rd_d    = 1'b0;
    dbg_win     = 1'b0;
    clear_busy  = 1'b0;
    ram_wren    = 1'b0;
    ram_address = vga_addr;
    ram_data    = '0;

    if (reset) begin
      state_d     = CLEAR_ON_RESET ? StClear : StRun;
      clear_ptr_d = '0;
      starve_d    = '0;
    end else begin
      unique case (state_q)
        StClear: begin
          clear_busy  = 1'b1;
          ram_wren    = 1'b1;
          ram_address = clear_ptr_q[ADDR_WIDTH-1:0];
          starve_d    = '0;
          clear_ptr_d = clear_ptr_q + 1'b1;
          if (clear_ptr_q == LastPtr) state_d = StRun;
        end
        StRun: begin
          // Debug is forced in once it has been denied DBG_MAX_WAIT cycles in a row.
          dbg_win = dbg_req && (!vga_req || (starve_q == StarveMax));
          if (dbg_win) begin
            ram_address = dbg_addr;
            ram_wren    = dbg_we;
            ram_data    = dbg_wdata;
            dbg_rd_d    = !dbg_we;
          end else if (vga_req) begin
            vga_slot_d = 1'b1;
          end

          if (dbg_req && !dbg_win) begin
            starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 1'b1;
          end else begin
            starve_d = '0;
          end

          if (clear_start) begin
            state_d     = StClear;
            clear_ptr_d = '0;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  assign dbg_gnt    = dbg_win;
  assign vga_rvalid = vga_slot_q;
  assign dbg_rvalid = dbg_rd_q;
  // Without a fresh return the last word is repeated so scanout stays stable.
  assign vga_rdata  = vga_slot_q ? ram_q : vga_hold_q;
  assign dbg_rdata  = dbg_rd_q   ? ram_q : dbg_hold_q;

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      state_q     <= state_d;
      clear_ptr_q <= '0;
      starve_q    <= '0;
      vga_slot_q  <= 1'b0;
      dbg_rd_q    <= 1'b0;
      vga_hold_q  <= '0;
      dbg_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      starve_q    <= starve_d;
      vga_slot_q  <= vga_slot_d;
      dbg_rd_q    <= dbg_rd_d;
      vga_hold_q  <= vga_rdata;
      dbg_hold_q  <= dbg_rdata;
    end
  end

endmodule

// File: tb/tb_ram_portb_scheduler.sv
// Bench for ram_portb_scheduler: directed scenarios plus randomized traffic, checked every
// cycle against a behavioural model of the port-B schedule and the RAM contents.
module tb_ram_portb_scheduler;

  localparam int DW    = 16;
  localparam int COUNT = 1024;
  localparam int AW    = 10;
  localparam int MAXW  = 15;

  logic          clk = 1'b0;
  logic          reset, clear_start, clear_busy;
  logic          vga_req, vga_rvalid;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_rdata;
  logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data, ram_q;
  logic          ram_wren;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_portb_scheduler #(
    .DATA_WIDTH        (DW),
    .RAM_REGISTER_COUNT(COUNT),
    .CLEAR_ON_RESET    (1'b1),
    .DBG_MAX_WAIT      (MAXW)
  ) dut (
    .CLK_50     (clk),
    .reset      (reset),
    .clear_start(clear_start),
    .clear_busy (clear_busy),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_rdata  (vga_rdata),
    .vga_rvalid (vga_rvalid),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rdata  (dbg_rdata),
    .dbg_rvalid (dbg_rvalid),
    .ram_address(ram_address),
    .ram_data   (ram_data),
    .ram_wren   (ram_wren),
    .ram_q      (ram_q)
  );

  // Port-B side of a synchronous RAM, read-old-data on collision.
  logic [DW-1:0] mem [COUNT] = '{default: 16'hDEAD};
  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [DW-1:0] ref_mem [COUNT] = '{default: 16'hDEAD};
  bit            m_clear = 1'b1;
  int            m_ptr = 0, m_starve = 0;
  bit            m_vpend = 1'b0, m_dpend = 1'b0;
  logic [DW-1:0] m_vexp = '0, m_dexp = '0, m_vhold = '0, m_dhold = '0;
  int            m_gnt_count = 0, m_clear_writes = 0;
  logic [DW-1:0] e_vdata, e_ddata;
  bit            win;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_vdata = m_vpend ? m_vexp : m_vhold;
      e_ddata = m_dpend ? m_dexp : m_dhold;
      chk("vga_rvalid", vga_rvalid, m_vpend);
      chk("vga_rdata",  vga_rdata,  e_vdata);
      chk("dbg_rvalid", dbg_rvalid, m_dpend);
      chk("dbg_rdata",  dbg_rdata,  e_ddata);
      if (reset) begin
        chk("rst_wren", ram_wren, 0);
        chk("rst_gnt",  dbg_gnt, 0);
        chk("rst_busy", clear_busy, 0);
        m_clear = 1'b1; m_ptr = 0; m_starve = 0;
        m_vpend = 1'b0; m_dpend = 1'b0; m_vhold = '0; m_dhold = '0;
      end else if (m_clear) begin
        chk("clr_busy", clear_busy, 1);
        chk("clr_wren", ram_wren, 1);
        chk("clr_addr", ram_address, m_ptr);
        chk("clr_data", ram_data, 0);
        chk("clr_gnt",  dbg_gnt, 0);
        ref_mem[m_ptr] = '0;
        m_clear_writes++;
        m_ptr++;
        if (m_ptr == COUNT) m_clear = 1'b0;
        m_starve = 0;
        m_vpend = 1'b0; m_dpend = 1'b0;
        m_vhold = e_vdata; m_dhold = e_ddata;
      end else begin
        win = dbg_req && (!vga_req || m_starve == MAXW);
        chk("run_busy", clear_busy, 0);
        chk("run_gnt",  dbg_gnt, win);
        if (win) begin
          chk("dbg_addr_out", ram_address, dbg_addr);
          chk("dbg_wren_out", ram_wren, dbg_we);
          chk("dbg_data_out", ram_data, dbg_wdata);
          m_dexp  = ref_mem[dbg_addr];
          m_dpend = !dbg_we;
          if (dbg_we) ref_mem[dbg_addr] = dbg_wdata;
          m_vpend = 1'b0;
          m_gnt_count++;
        end else begin
          chk("vga_wren_out", ram_wren, 0);
          chk("vga_addr_out", ram_address, vga_addr);
          if (!vga_req) chk("idle_data_out", ram_data, 0);
          m_vpend = vga_req;
          m_vexp  = ref_mem[vga_addr];
          m_dpend = 1'b0;
        end
        if (dbg_req && !win) m_starve = (m_starve < MAXW) ? m_starve + 1 : MAXW;
        else m_starve = 0;
        if (clear_start) begin
          m_clear = 1'b1;
          m_ptr   = 0;
        end
        m_vhold = e_vdata; m_dhold = e_ddata;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Measures a fill from its first cycle; leaves time mid-way through the first RUN cycle.
  task automatic run_clear(input string nm);
    int n;
    bit seq_ok;
    int model_start;
    n = 0;
    seq_ok = 1'b1;
    model_start = m_clear_writes;
    #2;
    while (clear_busy === 1'b1 && n < 1100) begin
      if (ram_address !== n[AW-1:0] || ram_wren !== 1'b1) seq_ok = 1'b0;
      n++;
      tick();
      #2;
    end
    chk({nm, "_len"}, n, 1024);
    chk({nm, "_seq"}, seq_ok, 1);
    chk({nm, "_model_len"}, m_clear_writes - model_start, 1024);
  endtask

  logic [DW-1:0] pre [32];
  logic [DW-1:0] vd;
  int            c, nz, issued_at, dens;
  bit            pend;

  initial begin
    reset = 1'b1; clear_start = 1'b0;
    vga_req = 1'b0; vga_addr = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    tick(); tick(); tick();

    // 1: fill after reset release
    reset = 1'b0;
    run_clear("fill");
    nz = 0;
    for (int i = 0; i < COUNT; i++) if (mem[i] !== '0) nz++;
    chk("ram_all_zero", nz, 0);

    // 2: preload through debug writes, then stream VGA reads
    for (int i = 0; i < 32; i++) begin
      tick();
      pre[i] = DW'($urandom);
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = AW'(i); dbg_wdata = pre[i];
      #2;
      chk("preload_gnt", dbg_gnt, 1);
    end
    tick();
    dbg_req = 1'b0;
    for (int i = 0; i <= 32; i++) begin
      tick();
      vga_req  = (i < 32);
      vga_addr = AW'(i);
      #2;
      if (i > 0) begin
        chk("vga_stream_valid", vga_rvalid, 1);
        chk("vga_stream_data", vga_rdata, pre[i-1]);
      end
    end

    // 3: debug write then read of address 5
    tick();
    vga_req = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'd5; dbg_wdata = 16'hBEEF;
    #2;
    chk("dbgw_gnt", dbg_gnt, 1);
    chk("dbgw_wren", ram_wren, 1);
    tick();
    dbg_we = 1'b0;
    #2;
    chk("dbgr_gnt", dbg_gnt, 1);
    tick();
    dbg_req = 1'b0;
    #2;
    chk("dbgr_rvalid", dbg_rvalid, 1);
    chk("dbgr_rdata", dbg_rdata, 16'hBEEF);

    // 4: starvation bound against continuous VGA traffic
    tick();
    vga_req = 1'b1; vga_addr = 10'd7;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'd3;
    c = 0;
    #2;
    while (dbg_gnt !== 1'b1 && c < 40) begin
      c++;
      tick();
      #2;
    end
    chk("starve_gnt_cycle", c, 15);
    vd = vga_rdata;
    chk("starve_vga_word", vd, pre[7]);
    tick();
    dbg_req = 1'b0;
    #2;
    chk("starve_vga_rvalid", vga_rvalid, 0);
    chk("starve_vga_hold", vga_rdata, vd);
    chk("starve_dbg_rdata", dbg_rdata, pre[3]);

    // 5: clear request with debug pending
    tick();
    clear_start = 1'b1; vga_req = 1'b1;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'd9;
    #2;
    chk("cs_vga_wins", dbg_gnt, 0);
    tick();
    clear_start = 1'b0; vga_req = 1'b0;
    c = 0;
    #2;
    while (dbg_gnt !== 1'b1 && c < 1100) begin
      c++;
      tick();
      #2;
    end
    chk("cs_dbg_wait", c, 1024);
    tick();
    dbg_req = 1'b0;

    // 6: reset in the middle of a fill
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 300; i++) tick();
    #2;
    chk("mid_fill_ptr", ram_address, 300);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_clear("refill");

    // Randomized traffic with varying VGA load
    pend = 1'b0;
    issued_at = 0;
    dens = 50;
    for (int k = 0; k < 4000; k++) begin
      tick();
      if (k % 200 == 0) dens = $urandom_range(0, 100);
      reset       = ($urandom_range(0, 2999) == 0);
      clear_start = !reset && ($urandom_range(0, 1499) == 0);
      vga_req     = ($urandom_range(0, 99) < dens);
      vga_addr    = AW'($urandom_range(0, 63));
      if (pend && m_gnt_count != issued_at) pend = 1'b0;
      if (!pend && $urandom_range(0, 3) == 0) begin
        pend      = 1'b1;
        issued_at = m_gnt_count;
        dbg_we    = 1'($urandom);
        dbg_addr  = AW'($urandom_range(0, 63));
        dbg_wdata = DW'($urandom);
      end
      dbg_req = pend;
    end

    tick();
    reset = 1'b0; clear_start = 1'b0; vga_req = 1'b0; dbg_req = 1'b0;
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares",
             n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule
